// File: rtl/stream_demux_if.sv
// Handshake bundle for the one-to-N stream demultiplexer: one upstream port, N downstream channels.
interface stream_demux_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [SW-1:0]     in_sel;
    logic [W-1:0]      in_data;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_ready;
    logic [N*W-1:0]    out_data;
    logic              sel_err;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, sel_err
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, sel_err
    );
endinterface

// File: rtl/stream_demux.sv
// One-to-N stream demultiplexer with a one-entry registered buffer per output channel.
module stream_demux #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    stream_demux_if.slave bus
);
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

    buf_state_e     state_q [N];
    buf_state_e     state_d [N];
    logic [W-1:0]   data_q  [N];
    logic [N-1:0]   load;
    logic [N-1:0]   drain;
    logic           sel_ok;
    logic           ready_c;
    logic           accept;
    logic           sel_err_d;
    logic           sel_err_q;
    logic [N-1:0]   out_valid_c;
    logic [N*W-1:0] out_data_c;

    // Per-channel next state; in_ready depends only on in_sel, buffer state and out_ready.
    always_comb begin
        sel_ok    = 1'b0;
        ready_c   = 1'b1;
        accept    = 1'b0;
        sel_err_d = 1'b0;
        load      = '0;
        drain     = '0;
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            drain[i]   = (state_q[i] == FULL) & bus.out_ready[i];
            if (bus.in_sel == SW'(i)) begin
                sel_ok  = 1'b1;
                ready_c = (state_q[i] == EMPTY) | bus.out_ready[i];
            end
        end
        ready_c   = ready_c & rst_n;
        accept    = bus.in_valid & ready_c;
        sel_err_d = accept & ~sel_ok;
        for (int i = 0; i < N; i++) begin
            load[i] = accept & (bus.in_sel == SW'(i));
            case (state_q[i])
                EMPTY: if (load[i])              state_d[i] = FULL;
                FULL:  if (drain[i] & ~load[i])  state_d[i] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= EMPTY;
                data_q[i]  <= '0;
            end
            sel_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                if (load[i]) data_q[i] <= bus.in_data;
            end
            sel_err_q <= sel_err_d;
        end
    end

    // Flatten channel buffers onto the downstream bus.
    always_comb begin
        out_valid_c = '0;
        out_data_c  = '0;
        for (int i = 0; i < N; i++) begin
            out_valid_c[i]        = (state_q[i] == FULL);
            out_data_c[i*W +: W]  = data_q[i];
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;
    assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed table, hand sequences, and random traffic against a queue model.
module tb_stream_demux;
    logic clk = 1'b0;
    logic rst_n;
    int unsigned vecs = 0;
    int unsigned miss = 0;

    stream_demux_if #(.N(4), .W(8)) b4 ();
    stream_demux_if #(.N(3), .W(8)) b3 ();

    stream_demux #(.N(4), .W(8)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    stream_demux #(.N(3), .W(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [7:0] d;
        logic [3:0] ordy;
        logic       rdy;
        logic [3:0] ov;
        logic [7:0] slice;
        logic       err;
    } vec_t;

    vec_t tbl [11];

    // Reference model: per-channel FIFO of accepted words plus last loaded word per slice.
    logic [7:0] mq [8][$];
    logic [7:0] mlast [8];
    logic       mbad [2];
    int         nch [2] = '{4, 3};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [1:0] sel,
                         input logic [7:0] data, input logic [3:0] ordy);
        if (d == 0) begin
            b4.in_valid = v; b4.in_sel = sel; b4.in_data = data; b4.out_ready = ordy;
        end else begin
            b3.in_valid = v; b3.in_sel = sel; b3.in_data = data; b3.out_ready = ordy[2:0];
        end
    endtask

    function automatic logic [63:0] rd_ready(input int d);
        return (d == 0) ? 64'(b4.in_ready) : 64'(b3.in_ready);
    endfunction
    function automatic logic [63:0] rd_ov(input int d);
        return (d == 0) ? 64'(b4.out_valid) : 64'(b3.out_valid);
    endfunction
    function automatic logic [63:0] rd_data(input int d);
        return (d == 0) ? 64'(b4.out_data) : 64'(b3.out_data);
    endfunction
    function automatic logic [63:0] rd_err(input int d);
        return (d == 0) ? 64'(b4.sel_err) : 64'(b3.sel_err);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mreset();
        for (int k = 0; k < 8; k++) begin
            mq[k].delete();
            mlast[k] = 8'h00;
        end
        mbad[0] = 1'b0;
        mbad[1] = 1'b0;
    endtask

    function automatic logic mready(input int d, input logic [1:0] sel, input logic [3:0] ordy);
        if (int'(sel) >= nch[d]) return 1'b1;
        return (mq[d*4 + int'(sel)].size() == 0) || ordy[sel];
    endfunction

    task automatic mstep(input int d, input logic acc, input logic [1:0] sel,
                         input logic [7:0] data, input logic [3:0] ordy);
        for (int i = 0; i < nch[d]; i++)
            if (mq[d*4 + i].size() > 0 && ordy[i]) void'(mq[d*4 + i].pop_front());
        if (acc && int'(sel) < nch[d]) begin
            mq[d*4 + int'(sel)].push_back(data);
            mlast[d*4 + int'(sel)] = data;
        end
        mbad[d] = acc && (int'(sel) >= nch[d]);
    endtask

    function automatic logic [63:0] mexp_ov(input int d);
        logic [63:0] r = '0;
        for (int i = 0; i < nch[d]; i++) r[i] = (mq[d*4 + i].size() > 0);
        return r;
    endfunction

    function automatic logic [63:0] mexp_data(input int d);
        logic [63:0] r = '0;
        for (int i = 0; i < nch[d]; i++) r = r | (64'(mlast[d*4 + i]) << (i * 8));
        return r;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       cv   [2];
        logic [1:0] csel [2];
        logic [7:0] cdat [2];
        logic [3:0] cordy[2];
        logic       pend [2];
        logic       acc  [2];
        logic       er;
        logic [7:0] slice;

        tbl[0]  = '{1'b1, 2'd2, 8'hA5, 4'b1111, 1'b1, 4'b0100, 8'hA5, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 2'd1, 8'h11, 4'b1101, 1'b1, 4'b0010, 8'h11, 1'b0};
        tbl[3]  = '{1'b1, 2'd1, 8'h22, 4'b1101, 1'b0, 4'b0010, 8'h11, 1'b0};
        tbl[4]  = '{1'b1, 2'd1, 8'h22, 4'b1111, 1'b1, 4'b0010, 8'h22, 1'b0};
        tbl[5]  = '{1'b1, 2'd3, 8'h33, 4'b1101, 1'b1, 4'b1010, 8'h33, 1'b0};
        tbl[6]  = '{1'b0, 2'd1, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h22, 1'b0};
        tbl[7]  = '{1'b1, 2'd0, 8'h5A, 4'b1110, 1'b1, 4'b0001, 8'h5A, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 8'h77, 4'b1110, 1'b0, 4'b0001, 8'h5A, 1'b0};
        tbl[9]  = '{1'b1, 2'd0, 8'h77, 4'b1111, 1'b1, 4'b0001, 8'h77, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h77, 1'b0};

        // Reset held two cycles with traffic offered.
        rst_n = 1'b0;
        drive(0, 1'b1, 2'd2, 8'hA5, 4'hF);
        drive(1, 1'b1, 2'd3, 8'h7E, 4'h7);
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", rd_ready(d), 64'd0);
            check("rst_ov",    rd_ov(d),    64'd0);
            check("rst_data",  rd_data(d),  64'd0);
            check("rst_err",   rd_err(d),   64'd0);
        end
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 4; s++) begin
                drive(d, 1'b0, 2'(s), 8'h00, 4'h0);
                #1;
                check("rel_ready", rd_ready(d), 64'd1);
            end
        tick();

        // Directed table on the 4-channel instance.
        for (int t = 0; t < 11; t++) begin
            drive(0, tbl[t].v, tbl[t].sel, tbl[t].d, tbl[t].ordy);
            #1;
            check("tbl_ready", rd_ready(0), 64'(tbl[t].rdy));
            tick();
            slice = b4.out_data[int'(tbl[t].sel)*8 +: 8];
            check("tbl_ov",    rd_ov(0),    64'(tbl[t].ov));
            check("tbl_slice", 64'(slice),  64'(tbl[t].slice));
            check("tbl_err",   rd_err(0),   64'(tbl[t].err));
        end

        // Streaming 16 words into channel 0 without gaps.
        for (int k = 0; k < 16; k++) begin
            drive(0, 1'b1, 2'd0, 8'(k), 4'hF);
            #1;
            check("strm_ready", rd_ready(0), 64'd1);
            tick();
            check("strm_ov",   rd_ov(0), 64'd1);
            check("strm_data", 64'(b4.out_data[7:0]), 64'(k));
        end
        drive(0, 1'b0, 2'd0, 8'h00, 4'hF);
        tick();
        check("strm_end_ov", rd_ov(0), 64'd0);

        // Out-of-range select on the 3-channel instance, back to back.
        drive(1, 1'b1, 2'd3, 8'h7E, 4'h7);
        #1;
        check("oor_ready", rd_ready(1), 64'd1);
        tick();
        check("oor_err1", rd_err(1), 64'd1);
        check("oor_ov1",  rd_ov(1),  64'd0);
        drive(1, 1'b1, 2'd3, 8'h7F, 4'h7);
        tick();
        check("oor_err2", rd_err(1), 64'd1);
        drive(1, 1'b0, 2'd0, 8'h00, 4'h7);
        tick();
        check("oor_err3", rd_err(1), 64'd0);
        check("oor_ov3",  rd_ov(1),  64'd0);

        // Reset while channels 0 and 2 hold undelivered words.
        drive(0, 1'b1, 2'd0, 8'hC0, 4'h0);
        tick();
        drive(0, 1'b1, 2'd2, 8'hC2, 4'h0);
        tick();
        check("mid_full_ov", rd_ov(0), 64'h5);
        rst_n = 1'b0;
        drive(0, 1'b0, 2'd0, 8'h00, 4'h0);
        tick();
        check("mid_rst_ov",    rd_ov(0),    64'd0);
        check("mid_rst_data",  rd_data(0),  64'd0);
        check("mid_rst_ready", rd_ready(0), 64'd0);
        rst_n = 1'b1;
        drive(0, 1'b1, 2'd1, 8'h5C, 4'hF);
        #1;
        check("mid_rel_ready", rd_ready(0), 64'd1);
        tick();
        check("mid_rel_ov",    rd_ov(0), 64'h2);
        check("mid_rel_slice", 64'(b4.out_data[15:8]), 64'h5C);
        drive(0, 1'b0, 2'd0, 8'h00, 4'hF);
        tick();
        check("mid_end_ov", rd_ov(0), 64'd0);

        // Random traffic on both instances against the queue model.
        rst_n = 1'b0;
        drive(0, 1'b0, 2'd0, 8'h00, 4'h0);
        drive(1, 1'b0, 2'd0, 8'h00, 4'h0);
        tick();
        rst_n = 1'b1;
        mreset();
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (!pend[d]) begin
                    cv[d]   = ($urandom % 4) != 0;
                    csel[d] = 2'($urandom % 4);
                    cdat[d] = 8'($urandom);
                end
                cordy[d] = 4'($urandom) | 4'($urandom);
                drive(d, cv[d], csel[d], cdat[d], cordy[d]);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                er = mready(d, csel[d], cordy[d]);
                check("rnd_ready", rd_ready(d), 64'(er));
                acc[d] = cv[d] && er;
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                mstep(d, acc[d], csel[d], cdat[d], cordy[d]);
                check("rnd_ov",   rd_ov(d),   mexp_ov(d));
                check("rnd_data", rd_data(d), mexp_data(d));
                check("rnd_err",  rd_err(d),  64'(mbad[d]));
                pend[d] = cv[d] && !acc[d];
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
